// File: rtl/bus_arbiter_if.sv
// Bus-request/grant bundle between the control unit (requesters) and the bus arbiter.
// The master side is the arbiter that owns the grant outputs.
interface bus_arbiter_if #(
    parameter int NUM_SRC = 24,
    parameter int SEL_W   = 5
);
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] grant;
    logic [SEL_W-1:0]   select;
    logic               bus_busy;
    logic               turnaround;
    logic               preempted;

    modport master (
        input  req,
        output grant,
        output select,
        output bus_busy,
        output turnaround,
        output preempted
    );

    modport slave (
        output req,
        input  grant,
        input  select,
        input  bus_busy,
        input  turnaround,
        input  preempted
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin owner arbitration for the shared 32-bit datapath bus: one-hot grant,
// bounded hold time with preemption and a dead turnaround cycle between owners.
module bus_arbiter #(
    parameter int NUM_SRC  = 24,
    parameter int SEL_W    = 5,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          clr_n,
    bus_arbiter_if.master bus
);
    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [SEL_W:0]    SRC_COUNT = (SEL_W+1)'(NUM_SRC);

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    state_t              stateReg;
    logic [SEL_W-1:0]    rrPtrReg;
    logic [HOLD_W-1:0]   holdCntReg;
    logic [NUM_SRC-1:0]  grantReg;
    logic [SEL_W-1:0]    selectReg;
    logic                busyReg;
    logic                turnReg;
    logic                preemptReg;

    // Requests rotated so that position 0 is the current round-robin head.
    logic [NUM_SRC-1:0]  rotReq;
    logic [SEL_W-1:0]    rotIdx [NUM_SRC];

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_rot
        logic [SEL_W:0]   sum;
        logic [SEL_W-1:0] idx;
        always_comb begin
            sum = {1'b0, rrPtrReg} + (SEL_W+1)'(gi);
            idx = (sum >= SRC_COUNT) ? SEL_W'(sum - SRC_COUNT) : sum[SEL_W-1:0];
        end
        assign rotIdx[gi] = idx;
        assign rotReq[gi] = bus.req[idx];
    end

    logic             found;
    logic [SEL_W-1:0] winner;

    // Scan from the far end so the lowest rotated position wins last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (rotReq[i]) begin
                found  = 1'b1;
                winner = rotIdx[i];
            end
        end
    end

    logic ownerReq;
    logic othersPending;

    assign ownerReq      = bus.req[selectReg];
    assign othersPending = |(bus.req & ~grantReg);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            stateReg   <= IDLE;
            rrPtrReg   <= '0;
            holdCntReg <= '0;
            grantReg   <= '0;
            selectReg  <= '0;
            busyReg    <= 1'b0;
            turnReg    <= 1'b0;
            preemptReg <= 1'b0;
        end else begin
            turnReg    <= 1'b0;
            preemptReg <= 1'b0;
            case (stateReg)
                IDLE, TURN: begin
                    holdCntReg <= '0;
                    if (found) begin
                        stateReg  <= OWN;
                        grantReg  <= NUM_SRC'(1) << winner;
                        selectReg <= winner;
                        busyReg   <= 1'b1;
                    end else begin
                        stateReg  <= IDLE;
                        grantReg  <= '0;
                        selectReg <= '0;
                        busyReg   <= 1'b0;
                    end
                end
                OWN: begin
                    // A release in the same cycle as a hold expiry counts as release.
                    if (!ownerReq || (holdCntReg == HOLD_LAST && othersPending)) begin
                        stateReg   <= TURN;
                        grantReg   <= '0;
                        selectReg  <= '0;
                        busyReg    <= 1'b0;
                        turnReg    <= 1'b1;
                        preemptReg <= ownerReq;
                        holdCntReg <= '0;
                        rrPtrReg   <= (selectReg == SEL_W'(NUM_SRC - 1)) ? '0
                                                                         : selectReg + 1'b1;
                    end else if (holdCntReg != HOLD_LAST) begin
                        holdCntReg <= holdCntReg + 1'b1;
                    end
                end
                default: begin
                    stateReg  <= IDLE;
                    grantReg  <= '0;
                    selectReg <= '0;
                    busyReg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant      = grantReg;
    assign bus.select     = selectReg;
    assign bus.bus_busy   = busyReg;
    assign bus.turnaround = turnReg;
    assign bus.preempted  = preemptReg;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized checks of the round-robin bus arbiter.
module tb_bus_arbiter;
    localparam int N = 24;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    bus_arbiter_if #(.NUM_SRC(N), .SEL_W(5)) busIf ();

    bus_arbiter #(.NUM_SRC(N), .SEL_W(5), .MAX_HOLD(8)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (busIf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expectOut(input string tag, input logic [N-1:0] g, input logic [4:0] s,
                             input logic busy, input logic turn, input logic pre);
        chk({tag, ".grant"},      32'(busIf.grant),      32'(g));
        chk({tag, ".select"},     32'(busIf.select),     32'(s));
        chk({tag, ".bus_busy"},   32'(busIf.bus_busy),   32'(busy));
        chk({tag, ".turnaround"}, 32'(busIf.turnaround), 32'(turn));
        chk({tag, ".preempted"},  32'(busIf.preempted),  32'(pre));
        $display("step %-14s req=%06h grant=%06h sel=%0d busy=%0b turn=%0b pre=%0b",
                 tag, busIf.req, busIf.grant, busIf.select, busIf.bus_busy,
                 busIf.turnaround, busIf.preempted);
    endtask

    task automatic doReset();
        clr_n = 1'b0;
        tick(1);
        clr_n = 1'b1;
    endtask

    function automatic logic [N-1:0] bit1(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        int owners [4];
        logic [N-1:0] prevGrant;
        int idx;

        busIf.req = '0;
        tick(2);
        expectOut("reset", '0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Reset mid-ownership
        clr_n = 1'b1;
        busIf.req = bit1(5);
        tick(1);
        expectOut("own5", bit1(5), 5'd5, 1'b1, 1'b0, 1'b0);
        tick(2);
        clr_n = 1'b0;
        #1;
        expectOut("asyncrst", '0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick(1);
        expectOut("rsthold", '0, 5'd0, 1'b0, 1'b0, 1'b0);
        clr_n = 1'b1;
        tick(1);
        expectOut("regrant5", bit1(5), 5'd5, 1'b1, 1'b0, 1'b0);
        busIf.req = '0;
        tick(1);
        expectOut("turn5", '0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick(1);
        expectOut("idle5", '0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Single requester MDR, held 20 cycles with no preemption
        busIf.req = bit1(21);
        tick(1);
        expectOut("mdr", bit1(21), 5'd21, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 19; c++) begin
            tick(1);
            chk("mdr.hold", 32'(busIf.grant), 32'(bit1(21)));
            chk("mdr.nopre", 32'(busIf.preempted), 32'd0);
        end
        busIf.req = '0;
        tick(1);
        expectOut("mdrturn", '0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick(1);
        expectOut("mdridle", '0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Round robin among 0, 3, 20 with preemption at 8 cycles
        doReset();
        owners = '{0, 3, 20, 0};
        busIf.req = bit1(0) | bit1(3) | bit1(20);
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 8; c++) begin
                tick(1);
                chk("rr.grant",  32'(busIf.grant),     32'(bit1(owners[k])));
                chk("rr.select", 32'(busIf.select),    32'(owners[k]));
                chk("rr.nopre",  32'(busIf.preempted), 32'd0);
            end
            if (k < 3) begin
                tick(1);
                expectOut("rrturn", '0, 5'd0, 1'b0, 1'b1, 1'b1);
            end
        end
        tick(1);
        expectOut("rrturn4", '0, 5'd0, 1'b0, 1'b1, 1'b1);

        // Wrap-around: after owner 22, pointer 23 picks 23 before 1
        busIf.req = '0;
        doReset();
        busIf.req = bit1(22);
        tick(1);
        expectOut("own22", bit1(22), 5'd22, 1'b1, 1'b0, 1'b0);
        busIf.req = bit1(22) | bit1(23) | bit1(1);
        tick(1);
        expectOut("hold22", bit1(22), 5'd22, 1'b1, 1'b0, 1'b0);
        busIf.req = bit1(23) | bit1(1);
        tick(1);
        expectOut("turn22", '0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick(1);
        expectOut("own23", bit1(23), 5'd23, 1'b1, 1'b0, 1'b0);
        busIf.req = bit1(1);
        tick(1);
        expectOut("turn23", '0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick(1);
        expectOut("own1", bit1(1), 5'd1, 1'b1, 1'b0, 1'b0);
        busIf.req = '0;
        tick(2);
        expectOut("idle1", '0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Release coinciding with hold expiry counts as release
        busIf.req = bit1(4);
        tick(1);
        expectOut("own4", bit1(4), 5'd4, 1'b1, 1'b0, 1'b0);
        busIf.req = bit1(4) | bit1(9);
        tick(6);
        chk("own4.mid", 32'(busIf.grant), 32'(bit1(4)));
        tick(1);
        expectOut("own4last", bit1(4), 5'd4, 1'b1, 1'b0, 1'b0);
        busIf.req = bit1(9);
        tick(1);
        expectOut("relturn", '0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick(1);
        expectOut("own9", bit1(9), 5'd9, 1'b1, 1'b0, 1'b0);
        busIf.req = '0;
        tick(2);

        // Random traffic: structural bus-safety properties
        prevGrant = busIf.grant;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 5) == 0)
                busIf.req = N'($urandom & $urandom & $urandom);
            tick(1);
            chk("rnd.onehot", 32'($countones(busIf.grant) <= 1), 32'd1);
            idx = 0;
            for (int i = 0; i < N; i++)
                if (busIf.grant[i]) idx = i;
            chk("rnd.select", 32'(busIf.select), 32'(idx));
            chk("rnd.busy", 32'(busIf.bus_busy), 32'(|busIf.grant));
            chk("rnd.gap", 32'(prevGrant != '0 && busIf.grant != '0 && busIf.grant != prevGrant),
                32'd0);
            if (busIf.turnaround)
                chk("rnd.turnzero", 32'(busIf.grant), 32'd0);
            prevGrant = busIf.grant;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
